// File: rtl/adder_pkg.sv
// Shared types and default widths for the summing accumulator and its saturating adder.
package adder_pkg;

   localparam int SUM_W = 5;
   localparam int ACC_W = 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add: acc + zero-extended sample, clamped to all-ones.
module sat_add #(
   parameter int SUM_W = adder_pkg::SUM_W,
   parameter int ACC_W = adder_pkg::ACC_W
) (
   input  logic [ACC_W-1:0] a_i,
   input  logic [SUM_W-1:0] b_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             ovf_o
);

   logic [ACC_W:0] wide_sum;

   // One spare bit catches the carry out; any carry means the true sum exceeded ACC_W bits.
   assign wide_sum = {1'b0, a_i} + {{(ACC_W + 1 - SUM_W){1'b0}}, b_i};
   assign ovf_o    = wide_sum[ACC_W];
   assign sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a block of upstream adder results with saturation and hands the total downstream.
//
//   state | meaning
//   IDLE  | waiting for start_i; last result still visible on acc_o
//   ACCUM | accepting sum_i samples until count reaches the latched length
//   DONE  | result valid, held until downstream takes it with acc_ready_i
module sum_accumulator #(
   parameter int SUM_W = adder_pkg::SUM_W,
   parameter int ACC_W = adder_pkg::ACC_W,
   parameter int CNT_W = adder_pkg::CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic [SUM_W-1:0] sum_i,
   input  logic             sum_valid_i,
   output logic             sum_ready_o,
   output logic [ACC_W-1:0] acc_o,
   output logic             acc_valid_o,
   input  logic             acc_ready_i,
   output logic             ovf_o,
   output logic             busy_o
);
   import adder_pkg::*;

   localparam logic [CNT_W:0] FULL_LEN = (CNT_W + 1)'(2 ** CNT_W);
   localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

   state_e           state_q, state_d;
   logic [CNT_W:0]   len_q, len_d;
   logic [CNT_W:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             acc_valid_q, acc_valid_d;

   logic [ACC_W-1:0] sat_sum;
   logic             sat_ovf;
   logic [CNT_W:0]   cnt_inc;

   sat_add #(
      .SUM_W (SUM_W),
      .ACC_W (ACC_W)
   ) u_sat_add (
      .a_i   (acc_q),
      .b_i   (sum_i),
      .sum_o (sat_sum),
      .ovf_o (sat_ovf)
   );

   assign cnt_inc = cnt_q + CNT_ONE;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      acc_valid_d = acc_valid_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d   = (len_i == '0) ? FULL_LEN : {1'b0, len_i};
               cnt_d   = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (sum_valid_i) begin
               acc_d = sat_sum;
               ovf_d = ovf_q | sat_ovf;
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d     = DONE;
                  acc_valid_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (acc_ready_i) begin
               state_d     = IDLE;
               acc_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            acc_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         acc_valid_q <= acc_valid_d;
      end
   end

   assign sum_ready_o = (state_q == ACCUM);
   assign busy_o      = (state_q != IDLE);
   assign acc_o       = acc_q;
   assign ovf_o       = ovf_q;
   assign acc_valid_o = acc_valid_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter SUM_W, 5, width of adder result (4-bit sum plus carry).
REQ-002 SHALL have parameter ACC_W, 8, accumulator width.
REQ-003 SHALL have parameter CNT_W, 4, block-length field width (max block 2**CNT_W samples).
REQ-004 SHALL have port clk_i input 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni input 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start_i input 1: begin new block (honoured in IDLE only).
REQ-007 SHALL have port len_i input CNT_W: samples per block; 0 means 2**CNT_W.
REQ-008 SHALL have port sum_i input SUM_W: adder output consumed from upstream adder.
REQ-009 SHALL have port sum_valid_i input 1: sum_i valid this cycle.
REQ-010 SHALL have port sum_ready_o output 1: block accepts sum_i this cycle.
REQ-011 SHALL have port acc_o output ACC_W: block result.
REQ-012 SHALL have port acc_valid_o output 1: acc_o/ovf_o valid.
REQ-013 SHALL have port acc_ready_i input 1: downstream accepts result.
REQ-014 SHALL have port ovf_o output 1: sticky saturation flag for current block.
REQ-015 SHALL have port busy_o output 1: high in ACCUM or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-017 IDLE with start_i=1 SHALL latch len_i (0 -> 2**CNT_W), clear acc, count and ovf, and enter ACCUM next cycle.
REQ-018 sum_ready_o SHALL be 1 exactly when state is ACCUM (combinational from state, not from sum_valid_i).
REQ-019 A sample SHALL be accepted only on a cycle with sum_valid_i=1 and sum_ready_o=1; other cycles leave acc and count unchanged.
REQ-020 Each accepted sample SHALL update acc <= min(acc + zero-extended sum_i, 2**ACC_W-1) and increment count.
REQ-021 Saturation (unclamped sum > 2**ACC_W-1) SHALL set ovf, which stays set until the next start.
REQ-022 Acceptance of the sample making count equal the latched length SHALL move to DONE on that edge; acc_valid_o SHALL assert the following cycle (1-cycle latency from last sample).
REQ-023 In DONE acc_valid_o SHALL be 1; acc_o and ovf_o SHALL hold stable until acc_ready_i=1.
REQ-024 DONE with acc_ready_i=1 SHALL return to IDLE next cycle; acc_o retains its value, acc_valid_o drops.
REQ-025 start_i in ACCUM or DONE SHALL be ignored (no restart, no length change).
REQ-026 Counter SHALL be CNT_W+1 bits so length 2**CNT_W completes without wrap.

Reset
REQ-027 rst_ni low SHALL immediately force IDLE, acc_o=0, count=0, ovf_o=0, acc_valid_o=0, sum_ready_o=0, busy_o=0, regardless of state.
REQ-028 Reset mid-block SHALL discard partial result; no acc_valid_o pulse after reset release without a new start_i.

Structure
REQ-029 Package adder_pkg SHALL hold the state enum (IDLE/ACCUM/DONE) and default width constants SUM_W, ACC_W, CNT_W.
REQ-030 Saturating addition SHALL be a sub-module sat_add (combinational, ACC_W-bit result plus overflow bit); FSM, counter and registers stay in sum_accumulator.
REQ-031 Top-level bench SHALL instantiate the existing adder with s_o driving sum_i through the shared interface.

Verification
REQ-032 len_i=4, sums 3,5,7,9 back-to-back -> acc_o=24, ovf_o=0, acc_valid_o 1 cycle after 4th accept.
REQ-033 len_i=0, sixteen sums of 31 -> 16 accepts, acc_o=255, ovf_o=1 (set on 9th sample).
REQ-034 len_i=3, sum_valid_i gaps of 2 idle cycles between 1,2,3 -> acc_o=6, count unchanged during gaps.
REQ-035 Result ready with acc_ready_i held 0 for 5 cycles -> acc_o/acc_valid_o stable, sum_ready_o=0, start_i pulse ignored; IDLE cycle after acc_ready_i=1.
REQ-036 rst_ni low after 2 of len_i=4 samples -> all outputs 0 immediately; new start with len_i=1, sum 10 -> acc_o=10.
